// File: rtl/tx_enable_sequencer_if.sv
// Command/status bundle of the TX enable sequencer.
//   i_start, i_stop            : single-cycle start/stop commands
//   i_fast_valid, i_slow_valid : pacing strobes (66b side / 20-lane side)
//   o_enb                      : per-stage enables, bit 0 most upstream
//   o_state                    : 0 IDLE, 1 RAMP_UP, 2 RUNNING, 3 RAMP_DOWN
//   o_running, o_busy          : state flags
// master drives the commands and strobes; slave is the sequencer.
interface tx_enable_sequencer_if #(
  parameter int N_STAGES = 7
) ();
  logic                i_start;
  logic                i_stop;
  logic                i_fast_valid;
  logic                i_slow_valid;
  logic [N_STAGES-1:0] o_enb;
  logic [1:0]          o_state;
  logic                o_running;
  logic                o_busy;

  modport master (
    output i_start, i_stop, i_fast_valid, i_slow_valid,
    input  o_enb, o_state, o_running, o_busy
  );

  modport slave (
    input  i_start, i_stop, i_fast_valid, i_slow_valid,
    output o_enb, o_state, o_running, o_busy
  );
endinterface

// File: rtl/tx_enable_sequencer.sv
// Start/stop sequencer for the 100GbE PCS TX chain. Raises the per-stage
// enables upstream-first on start and drops them upstream-first on stop, so
// every stage only sees valid upstream data and downstream stages drain.
// Consecutive enable changes are separated by STAGE_DELAY qualifying strobes:
// i_fast_valid for stages below FIRST_SLOW_STAGE, i_slow_valid otherwise.
// Ports:
//   i_clock : clock, rising edge
//   i_reset : synchronous active-high reset (all enables low, IDLE)
//   bus     : command/strobe inputs and enable/status outputs (slave modport)
module tx_enable_sequencer #(
  parameter int N_STAGES         = 7,
  parameter int FIRST_SLOW_STAGE = 5,
  parameter int STAGE_DELAY      = 4,
  parameter int NB_DELAY         = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  tx_enable_sequencer_if.slave  bus
);

  // ptr must be able to step one past the last stage during the drain
  localparam int PW = $clog2(N_STAGES + 1);
  localparam logic [PW-1:0]       LAST_STAGE = PW'(N_STAGES - 1);
  localparam logic [NB_DELAY-1:0] CNT_LAST   =
    NB_DELAY'((STAGE_DELAY > 0) ? (STAGE_DELAY - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RAMP_UP   = 2'd1,
    S_RUNNING   = 2'd2,
    S_RAMP_DOWN = 2'd3
  } state_e;

  state_e                state_q;
  logic [N_STAGES-1:0]   enb_q;
  logic [PW-1:0]         ptr_q;
  logic [PW-1:0]         top_q;
  logic [NB_DELAY-1:0]   cnt_q;
  logic                  running_q;
  logic                  busy_q;

  logic                  strobe;
  logic                  advance;

  always_comb begin
    strobe  = (int'(ptr_q) >= FIRST_SLOW_STAGE) ? bus.i_slow_valid : bus.i_fast_valid;
    // Zero delay: change every cycle, no strobe required.
    // Otherwise the strobe that would bring the count to STAGE_DELAY
    // performs the change itself, so cnt never reaches STAGE_DELAY.
    advance = (STAGE_DELAY == 0) || (strobe && (cnt_q == CNT_LAST));
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      enb_q     <= '0;
      ptr_q     <= '0;
      top_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_start && !bus.i_stop) begin
            state_q  <= S_RAMP_UP;
            enb_q[0] <= 1'b1;
            ptr_q    <= PW'(1);
            cnt_q    <= '0;
            busy_q   <= 1'b1;
          end
        end

        S_RAMP_UP: begin
          if (bus.i_stop) begin
            // pending enable is abandoned; drain what is already up
            state_q  <= S_RAMP_DOWN;
            top_q    <= ptr_q - PW'(1);
            enb_q[0] <= 1'b0;
            ptr_q    <= PW'(1);
            cnt_q    <= '0;
          end else if (advance) begin
            enb_q[ptr_q] <= 1'b1;
            ptr_q        <= ptr_q + PW'(1);
            cnt_q        <= '0;
            if (ptr_q == LAST_STAGE) begin
              state_q   <= S_RUNNING;
              running_q <= 1'b1;
              busy_q    <= 1'b0;
            end
          end else if (strobe) begin
            cnt_q <= cnt_q + NB_DELAY'(1);
          end
        end

        S_RUNNING: begin
          if (bus.i_stop) begin
            state_q   <= S_RAMP_DOWN;
            top_q     <= LAST_STAGE;
            enb_q[0]  <= 1'b0;
            ptr_q     <= PW'(1);
            cnt_q     <= '0;
            running_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end

        S_RAMP_DOWN: begin
          // ptr past top means the last clear happened on the previous edge
          if (ptr_q > top_q) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            top_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (advance) begin
            enb_q[ptr_q] <= 1'b0;
            ptr_q        <= ptr_q + PW'(1);
            cnt_q        <= '0;
          end else if (strobe) begin
            cnt_q <= cnt_q + NB_DELAY'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.o_enb     = enb_q;
  assign bus.o_state   = state_q;
  assign bus.o_running = running_q;
  assign bus.o_busy    = busy_q;

endmodule

// File: tb/tb_tx_enable_sequencer.sv
module tb_tx_enable_sequencer;
  localparam int N     = 7;
  localparam int FSLOW = 5;
  localparam int LMAX  = 900;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, fast = 1'b0, slow = 1'b0;

  always #5 clk = ~clk;

  tx_enable_sequencer_if #(.N_STAGES(N)) bus0 ();
  tx_enable_sequencer_if #(.N_STAGES(N)) bus1 ();

  assign bus0.i_start = start;  assign bus1.i_start = start;
  assign bus0.i_stop  = stop;   assign bus1.i_stop  = stop;
  assign bus0.i_fast_valid = fast;  assign bus1.i_fast_valid = fast;
  assign bus0.i_slow_valid = slow;  assign bus1.i_slow_valid = slow;

  tx_enable_sequencer #(.N_STAGES(N), .FIRST_SLOW_STAGE(FSLOW), .STAGE_DELAY(4), .NB_DELAY(8))
    dut0 (.i_clock(clk), .i_reset(rst), .bus(bus0));
  tx_enable_sequencer #(.N_STAGES(N), .FIRST_SLOW_STAGE(FSLOW), .STAGE_DELAY(0), .NB_DELAY(8))
    dut1 (.i_clock(clk), .i_reset(rst), .bus(bus1));

  int n_cmp = 0;
  int n_mis = 0;
  int dly [2] = '{4, 0};

  // stimulus per cycle, reference expectations and observations per DUT
  int           len;
  bit           s_start [LMAX];
  bit           s_stop  [LMAX];
  bit           s_fast  [LMAX];
  bit           s_slow  [LMAX];
  logic [N-1:0] exp_enb [2][LMAX];
  int           exp_st  [2][LMAX];
  logic [N+3:0] obs     [2][LMAX];   // {o_enb, o_state, o_running, o_busy}

  function automatic void clear_stim(int n, bit f, bit s);
    len = n;
    for (int j = 0; j < LMAX; j++) begin
      s_start[j] = 1'b0; s_stop[j] = 1'b0; s_fast[j] = f; s_slow[j] = s;
    end
  endfunction

  function automatic bit qual(int k, int j);
    return (k >= FSLOW) ? s_slow[j] : s_fast[j];
  endfunction

  // Cycle at which stage k changes, given the previous change became visible
  // at cycle p: one cycle after the D-th qualifying strobe seen from p on.
  // Returns -1 with stop_cyc set if an honoured stop comes first.
  function automatic int find_change(int p, int k, int D, bit honour_stop, output int stop_cyc);
    int seen = 0;
    stop_cyc = -1;
    for (int j = p; j < len; j++) begin
      if (honour_stop && s_stop[j]) begin stop_cyc = j; return -1; end
      if (D == 0) return j + 1;
      if (qual(k, j)) begin
        seen++;
        if (seen == D) return j + 1;
      end
    end
    return len + 1;
  endfunction

  function automatic void fill(int d, int from, int to, logic [N-1:0] e, int st);
    for (int j = from; j <= to && j < len; j++) begin
      exp_enb[d][j] = e; exp_st[d][j] = st;
    end
  endfunction

  // Schedule-based model: walks command pulses and the strobe schedule.
  function automatic void build_model(int d);
    int D, c, s, p, k, ch, sc, top;
    bit stopped;
    logic [N-1:0] e;
    D = dly[d];
    c = 0;
    while (c < len) begin
      s = -1;
      for (int j = c; j < len; j++)
        if (s < 0 && s_start[j] && !s_stop[j]) s = j;
      if (s < 0) begin fill(d, c, len - 1, '0, 0); break; end
      fill(d, c, s, '0, 0);
      e = '0; e[0] = 1'b1; p = s + 1; stopped = 1'b0; top = N - 1;
      for (k = 1; k < N; k++) begin
        ch = find_change(p, k, D, 1'b1, sc);
        if (ch < 0) begin
          fill(d, p, sc, e, 1); top = k - 1; p = sc + 1; stopped = 1'b1;
          break;
        end
        fill(d, p, ch - 1, e, 1); e[k] = 1'b1; p = ch;
      end
      if (!stopped) begin
        sc = -1;
        for (int j = p; j < len; j++)
          if (sc < 0 && s_stop[j]) sc = j;
        if (sc < 0) begin fill(d, p, len - 1, e, 2); break; end
        fill(d, p, sc, e, 2); p = sc + 1;
      end
      e[0] = 1'b0;
      for (k = 1; k <= top; k++) begin
        ch = find_change(p, k, D, 1'b0, sc);
        fill(d, p, ch - 1, e, 3); e[k] = 1'b0; p = ch;
      end
      fill(d, p, p, e, 3);
      c = p + 1;
    end
  endfunction

  function automatic logic [N+3:0] expv(int d, int j);
    int s = exp_st[d][j];
    return {exp_enb[d][j], 2'(s), (s == 2), (s == 1 || s == 3)};
  endfunction

  task automatic run_scenario();
    build_model(0);
    build_model(1);
    start = 1'b0; stop = 1'b0; fast = 1'b0; slow = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      obs[0][j] = {bus0.o_enb, bus0.o_state, bus0.o_running, bus0.o_busy};
      obs[1][j] = {bus1.o_enb, bus1.o_state, bus1.o_running, bus1.o_busy};
      start = s_start[j]; stop = s_stop[j]; fast = s_fast[j]; slow = s_slow[j];
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; fast = 1'b1; slow = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus0.o_enb, bus0.o_state, bus0.o_running, bus0.o_busy} !== 11'b0) begin
      n_mis++;
      $display("FAIL reset_dut0: got %b want 0", {bus0.o_enb, bus0.o_state, bus0.o_running, bus0.o_busy});
    end
    n_cmp++;
    if ({bus1.o_enb, bus1.o_state, bus1.o_running, bus1.o_busy} !== 11'b0) begin
      n_mis++;
      $display("FAIL reset_dut1: got %b want 0", {bus1.o_enb, bus1.o_state, bus1.o_running, bus1.o_busy});
    end
  endtask

  task automatic test_ramp_fixed();
    int shown = 0;
    clear_stim(120, 1'b1, 1'b1);
    s_start[10] = 1'b1; s_stop[60] = 1'b1;
    run_scenario();
    for (int d = 0; d < 2; d++)
      for (int j = 0; j < len; j++) begin
        n_cmp++;
        if (obs[d][j] !== expv(d, j)) begin
          n_mis++;
          if (shown++ < 8) $display("FAIL ramp_fixed dut%0d cycle %0d: got %b want %b", d, j, obs[d][j], expv(d, j));
        end
      end
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (obs[0][11 + 4 * k][4 + k] !== 1'b1 || obs[0][10 + 4 * k][4 + k] !== 1'b0) begin
        n_mis++;
        $display("FAIL ramp_fixed_rise stage %0d: before/at %b/%b want 0/1", k, obs[0][10 + 4 * k][4 + k], obs[0][11 + 4 * k][4 + k]);
      end
    end
    n_cmp++;
    if (obs[0][10][3:2] !== 2'd0 || obs[0][11][3:2] !== 2'd1 || obs[0][34][3:1] !== 3'b010 || obs[0][35][3:1] !== 3'b101) begin
      n_mis++;
      $display("FAIL ramp_fixed_state: c10 %0d c11 %0d c34 %b c35 %b want 0 1 010 101", obs[0][10][3:2], obs[0][11][3:2], obs[0][34][3:1], obs[0][35][3:1]);
    end
  endtask

  task automatic test_rate_split();
    int shown = 0;
    int rise [N];
    clear_stim(850, 1'b0, 1'b0);
    for (int j = 0; j < len; j++) begin
      s_fast[j] = (j % 2 == 0);
      s_slow[j] = (j % 40 == 0);
    end
    s_start[10] = 1'b1; s_stop[400] = 1'b1;
    run_scenario();
    for (int d = 0; d < 2; d++)
      for (int j = 0; j < len; j++) begin
        n_cmp++;
        if (obs[d][j] !== expv(d, j)) begin
          n_mis++;
          if (shown++ < 8) $display("FAIL rate_split dut%0d cycle %0d: got %b want %b", d, j, obs[d][j], expv(d, j));
        end
      end
    for (int k = 0; k < N; k++) begin
      rise[k] = -1;
      for (int j = 0; j < len; j++)
        if (rise[k] < 0 && obs[0][j][4 + k] === 1'b1) rise[k] = j;
    end
    for (int k = 1; k < 5; k++) begin
      n_cmp++;
      if (rise[k] - rise[k - 1] !== 8 && k > 1 || k == 1 && rise[1] !== 19) begin
        n_mis++;
        $display("FAIL rate_split_spacing stage %0d: rise %0d prev %0d want spacing 8 (stage1 at 19)", k, rise[k], rise[k - 1]);
      end
    end
    n_cmp++;
    if (rise[5] !== 201 || rise[6] !== 361) begin
      n_mis++;
      $display("FAIL rate_split_slow: stage5 %0d stage6 %0d want 201 361", rise[5], rise[6]);
    end
  endtask

  task automatic test_stop_midramp();
    int shown = 0;
    logic [N-1:0] hi;
    clear_stim(60, 1'b1, 1'b1);
    s_start[10] = 1'b1; s_stop[20] = 1'b1;
    run_scenario();
    for (int d = 0; d < 2; d++)
      for (int j = 0; j < len; j++) begin
        n_cmp++;
        if (obs[d][j] !== expv(d, j)) begin
          n_mis++;
          if (shown++ < 8) $display("FAIL stop_midramp dut%0d cycle %0d: got %b want %b", d, j, obs[d][j], expv(d, j));
        end
      end
    hi = '0;
    for (int j = 0; j < len; j++) hi = hi | obs[0][j][N+3:4];
    n_cmp++;
    if (hi[6:3] !== 4'b0 || obs[0][20][N+3:4] !== 7'b0000111) begin
      n_mis++;
      $display("FAIL stop_midramp_bits: ever-high %b enb@20 %b want 000xxxx / 0000111", hi, obs[0][20][N+3:4]);
    end
    n_cmp++;
    if (obs[0][21][N+3:2] !== 9'b000011011 || obs[0][29][N+3:2] !== 9'b000000011 || obs[0][30][3:0] !== 4'b0000) begin
      n_mis++;
      $display("FAIL stop_midramp_drain: c21 %b c29 %b c30 %b want 000011011 000000011 0000", obs[0][21][N+3:2], obs[0][29][N+3:2], obs[0][30][3:0]);
    end
  endtask

  task automatic test_ignored_commands();
    int shown = 0;
    clear_stim(150, 1'b1, 1'b1);
    s_start[5] = 1'b1; s_stop[5] = 1'b1;
    s_start[20] = 1'b1; s_start[30] = 1'b1; s_start[55] = 1'b1;
    s_stop[70] = 1'b1; s_start[75] = 1'b1;
    run_scenario();
    for (int d = 0; d < 2; d++)
      for (int j = 0; j < len; j++) begin
        n_cmp++;
        if (obs[d][j] !== expv(d, j)) begin
          n_mis++;
          if (shown++ < 8) $display("FAIL ignored_cmds dut%0d cycle %0d: got %b want %b", d, j, obs[d][j], expv(d, j));
        end
      end
    n_cmp++;
    if (obs[0][6][3:2] !== 2'd0 || obs[0][56][3:1] !== 3'b101 || obs[0][95][3:2] !== 2'd3 || obs[0][96][3:2] !== 2'd0) begin
      n_mis++;
      $display("FAIL ignored_cmds_state: c6 %0d c56 %b c95 %0d c96 %0d want 0 101 3 0", obs[0][6][3:2], obs[0][56][3:1], obs[0][95][3:2], obs[0][96][3:2]);
    end
  endtask

  task automatic test_zero_delay();
    int shown = 0;
    clear_stim(60, 1'b0, 1'b0);
    for (int j = 0; j < len; j++) begin
      s_fast[j] = ($urandom % 10 == 0);
      s_slow[j] = ($urandom % 10 == 0);
    end
    s_start[5] = 1'b1; s_stop[30] = 1'b1;
    run_scenario();
    for (int j = 0; j < len; j++) begin
      n_cmp++;
      if (obs[1][j] !== expv(1, j)) begin
        n_mis++;
        if (shown++ < 8) $display("FAIL zero_delay cycle %0d: got %b want %b", j, obs[1][j], expv(1, j));
      end
    end
    for (int k = 0; k < N; k++) begin
      logic [N-1:0] want;
      want = '0;
      for (int b = 0; b <= k; b++) want[b] = 1'b1;
      n_cmp++;
      if (obs[1][6 + k][N+3:4] !== want) begin
        n_mis++;
        $display("FAIL zero_delay_step cycle %0d: got %b want %b", 6 + k, obs[1][6 + k][N+3:4], want);
      end
    end
  endtask

  task automatic test_random();
    int shown = 0;
    for (int it = 0; it < 3; it++) begin
      clear_stim(800, 1'b0, 1'b0);
      for (int j = 0; j < len; j++) begin
        s_fast[j]  = ($urandom % 2 == 0);
        s_slow[j]  = ($urandom % 8 == 0);
        s_start[j] = ($urandom % 25 == 0);
        s_stop[j]  = ($urandom % 70 == 0);
      end
      run_scenario();
      for (int d = 0; d < 2; d++)
        for (int j = 0; j < len; j++) begin
          n_cmp++;
          if (obs[d][j] !== expv(d, j)) begin
            n_mis++;
            if (shown++ < 8) $display("FAIL random it%0d dut%0d cycle %0d: got %b want %b", it, d, j, obs[d][j], expv(d, j));
          end
        end
    end
  endtask

  task automatic test_reset_midramp();
    int waited = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; fast = 1'b1; slow = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (bus0.o_enb !== 7'b0000111 && waited < 100) begin
      @(negedge clk); waited++;
    end
    n_cmp++;
    if (bus0.o_enb !== 7'b0000111) begin
      n_mis++;
      $display("FAIL reset_midramp_reach: o_enb %b want 0000111 within 100 cycles", bus0.o_enb);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_cmp++;
    if ({bus0.o_enb, bus0.o_state, bus0.o_running, bus0.o_busy} !== 11'b0 ||
        {bus1.o_enb, bus1.o_state, bus1.o_running, bus1.o_busy} !== 11'b0) begin
      n_mis++;
      $display("FAIL reset_midramp_clear: dut0 %b dut1 %b want 0", {bus0.o_enb, bus0.o_state, bus0.o_running, bus0.o_busy}, {bus1.o_enb, bus1.o_state, bus1.o_running, bus1.o_busy});
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if (bus0.o_enb !== 7'b0000001 || bus0.o_state !== 2'd1 || bus0.o_busy !== 1'b1) begin
      n_mis++;
      $display("FAIL reset_midramp_restart: enb %b state %0d busy %b want 0000001 1 1", bus0.o_enb, bus0.o_state, bus0.o_busy);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bus0.o_enb !== 7'b0000011) begin
      n_mis++;
      $display("FAIL reset_midramp_stage1: enb %b want 0000011", bus0.o_enb);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_fixed();
    test_rate_split();
    test_stop_midramp();
    test_ignored_commands();
    test_zero_delay();
    test_random();
    test_reset_midramp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
